// File: rtl/spram_arbiter.sv
// spram_arbiter
//   Shares one single-port SPRAM (one-cycle registered read) between two
//   requesters using round-robin priority with optional bounded burst
//   locking. Grants are combinational; the access happens at the current
//   clock edge, and read data comes back one cycle later with a per-requester
//   valid strobe.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   rN_req, rN_lock           request (held until granted), burst hint
//   rN_addr/data_in/mask/wr   access attributes of requester N
//   rN_gnt                    combinational grant
//   rN_valid                  one-cycle pulse: data_out carries N's read data
//   data_out                  shared read data (pass-through of mem_data_out)
//   mem_address/data_in/mask/wr   SPRAM control, zero when nothing granted
//   mem_data_out              SPRAM read data
module spram_arbiter #(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 14,
  parameter int MAX_BURST    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    r0_req,
  input  logic                    r0_lock,
  input  logic [ADDRESS_BITS-1:0] r0_addr,
  input  logic [BITS-1:0]         r0_data_in,
  input  logic [1:0]              r0_mask,
  input  logic                    r0_wr,
  input  logic                    r1_req,
  input  logic                    r1_lock,
  input  logic [ADDRESS_BITS-1:0] r1_addr,
  input  logic [BITS-1:0]         r1_data_in,
  input  logic [1:0]              r1_mask,
  input  logic                    r1_wr,
  output logic                    r0_gnt,
  output logic                    r1_gnt,
  output logic                    r0_valid,
  output logic                    r1_valid,
  output logic [BITS-1:0]         data_out,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [BITS-1:0]         mem_data_in,
  output logic [1:0]              mem_mask,
  output logic                    mem_wr,
  input  logic [BITS-1:0]         mem_data_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;

  localparam logic [4:0] BURST_LIMIT = 5'(MAX_BURST);

  logic [1:0] state;
  logic [3:0] bcnt;
  logic       last;
  logic [1:0] rdpend_p1;

  logic       gnt_lock;
  logic       burst_ok;

  // Grant selection: an active lock wins only while its owner still
  // requests; otherwise fall straight through to round-robin this cycle.
  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    if (!rst) begin
      if (state == LOCK0 && r0_req) begin
        r0_gnt = 1'b1;
      end else if (state == LOCK1 && r1_req) begin
        r1_gnt = 1'b1;
      end else if (r0_req && r1_req) begin
        r0_gnt = last;
        r1_gnt = ~last;
      end else begin
        r0_gnt = r0_req;
        r1_gnt = r1_req;
      end
    end
  end

  assign gnt_lock = r0_gnt ? r0_lock : r1_lock;
  assign burst_ok = ({1'b0, bcnt} + 5'd1) < BURST_LIMIT;

  // Memory-side mux, forced to zero when nothing is granted.
  always_comb begin
    mem_address = '0;
    mem_data_in = '0;
    mem_mask    = '0;
    mem_wr      = 1'b0;
    if (r0_gnt) begin
      mem_address = r0_addr;
      mem_data_in = r0_data_in;
      mem_mask    = r0_mask;
      mem_wr      = r0_wr;
    end else if (r1_gnt) begin
      mem_address = r1_addr;
      mem_data_in = r1_data_in;
      mem_mask    = r1_mask;
      mem_wr      = r1_wr;
    end
  end

  // Stage p0 -> p1: access issued at this edge, read returns next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bcnt      <= 4'd0;
      last      <= 1'b1;
      rdpend_p1 <= 2'b00;
    end else begin
      rdpend_p1 <= {r1_gnt & ~r1_wr, r0_gnt & ~r0_wr};
      if (r0_gnt || r1_gnt) begin
        last <= r1_gnt;
        if (gnt_lock && burst_ok) begin
          state <= r1_gnt ? LOCK1 : LOCK0;
          bcnt  <= bcnt + 4'd1;
        end else begin
          state <= IDLE;
          bcnt  <= 4'd0;
        end
      end else begin
        state <= IDLE;
        bcnt  <= 4'd0;
      end
    end
  end

  assign r0_valid = rdpend_p1[0];
  assign r1_valid = rdpend_p1[1];
  assign data_out = mem_data_out;

endmodule

// File: tb/tb_spram_arbiter.sv
// Testbench for spram_arbiter: a behavioural SPRAM stub, a table of
// per-cycle vectors with expected grants, and a queue of expected read
// returns checked one cycle after each granted read.
module tb_spram_arbiter;

  localparam int AW = 14;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          r0_req, r0_lock, r0_wr, r1_req, r1_lock, r1_wr;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_data_in, r1_data_in;
  logic [1:0]    r0_mask, r1_mask;
  logic          r0_gnt, r1_gnt, r0_valid, r1_valid;
  logic [DW-1:0] data_out;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in;
  logic [1:0]    mem_mask;
  logic          mem_wr;
  logic [DW-1:0] mem_data_out;

  always #5 clk = ~clk;

  spram_arbiter #(.BITS(DW), .ADDRESS_BITS(AW), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_lock(r0_lock), .r0_addr(r0_addr),
    .r0_data_in(r0_data_in), .r0_mask(r0_mask), .r0_wr(r0_wr),
    .r1_req(r1_req), .r1_lock(r1_lock), .r1_addr(r1_addr),
    .r1_data_in(r1_data_in), .r1_mask(r1_mask), .r1_wr(r1_wr),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_valid(r0_valid), .r1_valid(r1_valid),
    .data_out(data_out), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_mask(mem_mask), .mem_wr(mem_wr), .mem_data_out(mem_data_out)
  );

  // SPRAM stub with a backdoor used only for preloading during reset.
  logic [DW-1:0] ram [0:16383];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) begin
      ram[bd_addr] <= bd_data;
    end else if (mem_wr) begin
      if (mem_mask[1]) ram[mem_address][15:8] <= mem_data_in[15:8];
      if (mem_mask[0]) ram[mem_address][7:0]  <= mem_data_in[7:0];
    end
    mem_data_out <= ram[mem_address];
  end

  typedef struct {
    bit            rst;
    bit            q0, l0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic [1:0]    m0;
    bit            q1, l1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic [1:0]    m1;
    bit            eg0, eg1;
  } vec_t;

  typedef struct {
    int            due;
    bit            who;
    logic [DW-1:0] data;
  } sb_t;

  vec_t          vecs[$];
  sb_t           sbq[$];
  logic [DW-1:0] model_mem [0:16383];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;

  function automatic vec_t mk(input bit rs,
      input bit q0, input bit l0, input bit w0, input logic [AW-1:0] a0,
      input logic [DW-1:0] d0, input logic [1:0] m0,
      input bit q1, input bit l1, input bit w1, input logic [AW-1:0] a1,
      input logic [DW-1:0] d1, input logic [1:0] m1,
      input bit eg0, input bit eg1);
    vec_t v;
    v.rst = rs;
    v.q0 = q0; v.l0 = l0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.m0 = m0;
    v.q1 = q1; v.l1 = l1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.m1 = m1;
    v.eg0 = eg0; v.eg1 = eg1;
    return v;
  endfunction

  function automatic vec_t idle_v();
    return mk(0, 0, 0, 0, '0, '0, '0, 0, 0, 0, '0, '0, '0, 0, 0);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst;
    r0_req = v.q0; r0_lock = v.l0; r0_wr = v.w0;
    r0_addr = v.a0; r0_data_in = v.d0; r0_mask = v.m0;
    r1_req = v.q1; r1_lock = v.l1; r1_wr = v.w1;
    r1_addr = v.a1; r1_data_in = v.d1; r1_mask = v.m1;
  endtask

  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] m);
    model_mem[a] = {m[1] ? d[15:8] : model_mem[a][15:8], m[0] ? d[7:0] : model_mem[a][7:0]};
  endtask

  task automatic check(input vec_t v);
    sb_t         s;
    logic        e0, e1;
    logic [DW-1:0] ed;
    logic [32:0] eb;
    if (v.rst) sbq.delete();
    e0 = 1'b0; e1 = 1'b0; ed = '0;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      s  = sbq.pop_front();
      e0 = ~s.who;
      e1 = s.who;
      ed = s.data;
    end
    chk("valid", 64'({r0_valid, r1_valid}), 64'({e0, e1}));
    if (e0 || e1) chk("rdata", 64'(data_out), 64'(ed));
    chk("gnt", 64'({r0_gnt, r1_gnt}), 64'({v.eg0, v.eg1}));
    if (v.eg0)      eb = {v.w0, v.a0, v.d0, v.m0};
    else if (v.eg1) eb = {v.w1, v.a1, v.d1, v.m1};
    else            eb = '0;
    chk("membus", 64'({mem_wr, mem_address, mem_data_in, mem_mask}), 64'(eb));
    chk("dout_pass", 64'(data_out), 64'(mem_data_out));
    if (v.eg0) begin
      if (v.w0) model_write(v.a0, v.d0, v.m0);
      else      sbq.push_back('{due: cyc + 1, who: 1'b0, data: model_mem[v.a0]});
    end else if (v.eg1) begin
      if (v.w1) model_write(v.a1, v.d1, v.m1);
      else      sbq.push_back('{due: cyc + 1, who: 1'b1, data: model_mem[v.a1]});
    end
  endtask

  task automatic step(input vec_t v);
    apply(v);
    @(negedge clk);
    check(v);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [AW-1:0] a0, a1;
    bit            w;

    apply(idle_v());
    #1 rst = 1'b1;

    // Preload the SPRAM (and the model) while the arbiter is held in reset.
    for (int i = 0; i < 34; i++) begin
      if (i == 32)      begin bd_addr = 14'h0010; bd_data = 16'hBEEF; end
      else if (i == 33) begin bd_addr = 14'h0020; bd_data = 16'hFFFF; end
      else              begin bd_addr = 14'h0100 + 14'(i); bd_data = 16'h5A00 ^ (16'(i) * 16'h0111); end
      model_mem[bd_addr] = bd_data;
      bd_we = 1'b1;
      @(posedge clk);
      #1;
    end
    bd_we = 1'b0;

    // Reset state: requests are ignored while rst is high.
    vecs.push_back(mk(1, 1, 0, 0, 14'h010, '0, '0, 1, 0, 0, 14'h020, '0, '0, 0, 0));
    // Single read by R0.
    vecs.push_back(mk(0, 1, 0, 0, 14'h010, 16'h0, 2'b11, 0, 0, 0, '0, '0, '0, 1, 0));
    vecs.push_back(idle_v());
    // Masked writes then read-back, write visible on the very next cycle.
    vecs.push_back(mk(0, 0, 0, 0, '0, '0, '0, 1, 0, 1, 14'h020, 16'h1234, 2'b01, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, '0, '0, '0, 1, 0, 0, 14'h020, 16'h0, 2'b00, 0, 1));
    vecs.push_back(idle_v());
    vecs.push_back(mk(0, 1, 0, 1, 14'h020, 16'hABCD, 2'b10, 0, 0, 0, '0, '0, '0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 14'h020, 16'h0, 2'b11, 0, 0, 0, '0, '0, '0, 1, 0));
    vecs.push_back(idle_v());
    // Contention: R0 was last, so R1 wins first, then strict alternation.
    a0 = 14'h100; a1 = 14'h101;
    for (int k = 0; k < 6; k++) begin
      w = (k % 2 == 0);
      vecs.push_back(mk(0, 1, 0, 0, a0, '0, '0, 1, 0, 0, a1, '0, '0, !w, w));
      if (w) a1 += 14'd2; else a0 += 14'd2;
    end
    vecs.push_back(idle_v());
    // Burst: R0 locks; R1 wins the tie, then 8 R0 grants, R1 once, R0 again.
    vecs.push_back(mk(0, 1, 1, 0, 14'h108, '0, '0, 1, 0, 0, 14'h118, '0, '0, 0, 1));
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(0, 1, 1, 0, 14'h108 + 14'(k), '0, '0, 1, 0, 0, 14'h119, '0, '0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 14'h110, '0, '0, 1, 0, 0, 14'h119, '0, '0, 0, 1));
    // Lock release: three locked grants, then R0 drops REQ and R1 is served.
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0, 1, 1, 0, 14'h110 + 14'(k), '0, '0, 1, 0, 0, 14'h11A, '0, '0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 14'h113, '0, '0, 1, 0, 0, 14'h11A, '0, '0, 0, 1));
    vecs.push_back(idle_v());
    // Reset between an R1 read grant and its valid cycle.
    vecs.push_back(mk(0, 0, 0, 0, '0, '0, '0, 1, 0, 0, 14'h11B, '0, '0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 14'h11C, '0, '0, 1, 0, 0, 14'h11D, '0, '0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 14'h11C, '0, '0, 1, 0, 0, 14'h11D, '0, '0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, '0, '0, '0, 1, 0, 0, 14'h11D, '0, '0, 0, 1));
    vecs.push_back(idle_v());

    foreach (vecs[i]) step(vecs[i]);

    // Reset in the middle of an R1 burst with a read outstanding: lock and
    // LAST are cleared, so the following tie goes to R0.
    step(mk(0, 0, 0, 0, '0, '0, '0, 1, 1, 0, 14'h100, '0, '0, 0, 1));
    step(mk(0, 1, 0, 0, 14'h102, '0, '0, 1, 1, 0, 14'h101, '0, '0, 0, 1));
    step(mk(1, 1, 0, 0, 14'h102, '0, '0, 1, 1, 0, 14'h101, '0, '0, 0, 0));
    step(mk(0, 1, 0, 0, 14'h102, '0, '0, 1, 1, 0, 14'h101, '0, '0, 1, 0));
    step(mk(0, 0, 0, 0, '0, '0, '0, 1, 1, 0, 14'h101, '0, '0, 0, 1));
    step(idle_v());
    step(idle_v());

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
